// File: rtl/lmu_ctrl_param_if.sv
// LMU controller bus: patch-info head entry, upstream readiness, FSM state and datapath strobes.
// The master drives patch info and readiness; the slave (controller) drives state, selects and strobes.
interface lmu_ctrl_param_if #(
    parameter int NUM_OP = 2,
    parameter int CNT_BW = 11
);
    localparam int PCHTYPE_BW = 3;
    localparam int FACEBD_BW  = 2;
    localparam int OPCODE_BW  = 3;
    localparam int SELMEAS_BW = 7;

    logic                         pchinfo_valid;
    logic [PCHTYPE_BW-1:0]        pchtype;
    logic [FACEBD_BW-1:0]         facebd_n;
    logic [NUM_OP*OPCODE_BW-1:0]  pchops;
    logic                         dqmeas_ready;
    logic                         aqmeas_ready;
    logic                         pf_ready;
    logic                         pchinfo_rdlast;
    logic                         instinfo_rdlast;
    logic [7:0]                   abcd_reg;
    logic                         err_clr;

    logic [1:0]                   state;
    logic [NUM_OP*SELMEAS_BW-1:0] sel_meases;
    logic [NUM_OP-1:0]            initmeas_wrens;
    logic                         initmeas_rst;
    logic                         pchinfo_pop;
    logic                         flip_initmeas_wr;
    logic                         finmeas_wren;
    logic                         byproduct_wren;
    logic                         abcd_rst;
    logic                         lqsign_temp_wren;
    logic                         lqsign_temp_rst;
    logic                         lqsign_acc_wren;
    logic [CNT_BW-1:0]            pch_cnt;
    logic                         overflow_err;

    modport master (
        output pchinfo_valid, pchtype, facebd_n, pchops, dqmeas_ready, aqmeas_ready, pf_ready,
               pchinfo_rdlast, instinfo_rdlast, abcd_reg, err_clr,
        input  state, sel_meases, initmeas_wrens, initmeas_rst, pchinfo_pop, flip_initmeas_wr,
               finmeas_wren, byproduct_wren, abcd_rst, lqsign_temp_wren, lqsign_temp_rst,
               lqsign_acc_wren, pch_cnt, overflow_err
    );

    modport slave (
        input  pchinfo_valid, pchtype, facebd_n, pchops, dqmeas_ready, aqmeas_ready, pf_ready,
               pchinfo_rdlast, instinfo_rdlast, abcd_reg, err_clr,
        output state, sel_meases, initmeas_wrens, initmeas_rst, pchinfo_pop, flip_initmeas_wr,
               finmeas_wren, byproduct_wren, abcd_rst, lqsign_temp_wren, lqsign_temp_rst,
               lqsign_acc_wren, pch_cnt, overflow_err
    );
endinterface

// File: rtl/lmu_ctrl_param.sv
// LMU controller: READY/PRODUCTING/INTERPRETING/BPUPDATING sequencer with per-slot measurement selects.
// A start is seen one cycle after readiness and PRODUCTING begins the cycle after; strobes are combinational.
module lmu_ctrl_param #(
    parameter int NUM_OP     = 2,
    parameter int BPU_CYCLES = 1,
    parameter int MAX_PCH    = 1024,
    parameter int CNT_BW     = 11
) (
    input  logic            clk,
    input  logic            rst,
    lmu_ctrl_param_if.slave bus
);
    localparam int PCHTYPE_BW = 3;
    localparam int FACEBD_BW  = 2;
    localparam int OPCODE_BW  = 3;
    localparam int SELLOC_BW  = 4;
    localparam int SELMEAS_BW = SELLOC_BW + 3;
    localparam int BPU_BW     = (BPU_CYCLES > 1) ? $clog2(BPU_CYCLES) : 1;

    localparam logic [OPCODE_BW-1:0]  OP_PPM_INTERPRET = 3'd1;
    localparam logic [OPCODE_BW-1:0]  OP_LQM_X = 3'd2;
    localparam logic [OPCODE_BW-1:0]  OP_LQM_Y = 3'd3;
    localparam logic [OPCODE_BW-1:0]  OP_LQM_Z = 3'd4;
    localparam logic [PCHTYPE_BW-1:0] PT_ZT = 3'd0, PT_ZB = 3'd1, PT_MT = 3'd2;
    localparam logic [PCHTYPE_BW-1:0] PT_MB = 3'd3, PT_M = 3'd4, PT_X = 3'd5;
    localparam logic [FACEBD_BW-1:0]  FACEBD_PP = 2'd2;
    localparam logic [SELLOC_BW-1:0]  SELLOC_ALL = 4'd0, SELLOC_I = 4'd1, SELLOC_E = 4'd2;
    localparam logic [SELLOC_BW-1:0]  SELLOC_W = 4'd3, SELLOC_S = 4'd4, SELLOC_NE = 4'd5;
    localparam logic [SELLOC_BW-1:0]  SELLOC_EXE = 4'd6, SELLOC_WINV = 4'd7, SELLOC_SINV = 4'd8;
    localparam logic [SELLOC_BW-1:0]  SELLOC_WS = 4'd9;
    localparam logic SEL_DQ = 1'b0, SEL_AQ = 1'b1, SEL_Z = 1'b0, SEL_X = 1'b1;
    localparam logic [SELMEAS_BW-1:0] SEL_IDLE = {SELLOC_ALL, SEL_DQ, SEL_Z, 1'b0};
    localparam logic [CNT_BW-1:0]     CNT_MAX  = CNT_BW'(MAX_PCH);
    localparam logic [BPU_BW-1:0]     BPU_LAST = BPU_BW'(BPU_CYCLES - 1);

    typedef enum logic [1:0] {
        LMU_READY        = 2'd0,
        LMU_PRODUCTING   = 2'd1,
        LMU_INTERPRETING = 2'd2,
        LMU_BPUPDATING   = 2'd3
    } lmu_state_e;

    lmu_state_e                   state_q, state_d;
    logic [BPU_BW-1:0]            bpu_cnt_q, bpu_cnt_d;
    logic [CNT_BW-1:0]            pch_cnt_q, pch_cnt_d;
    logic                         overflow_err_q, overflow_err_d;
    logic                         new_array_ing_q, pchinfo_rdlast_q;
    logic [NUM_OP-1:0]            sel_vld_q, sel_vld;
    logic [NUM_OP*SELMEAS_BW-1:0] sel_meases;
    logic                         any_dq, any_pp, all_ready, new_array_ing, overflow_set;
    logic                         abcd_valid, a_v, b_v, c_v, d_v;

    // Odd slots of a merge patch read the mirrored west boundary.
    function automatic logic [SELMEAS_BW-1:0] sel_slot(
        input logic [OPCODE_BW-1:0]  op,
        input logic [PCHTYPE_BW-1:0] pt,
        input logic [FACEBD_BW-1:0]  fb,
        input logic                  odd
    );
        logic [SELLOC_BW-1:0] loc;
        logic                 dqaq, xz, vld;
        loc  = SELLOC_ALL;
        dqaq = SEL_DQ;
        xz   = SEL_Z;
        vld  = 1'b1;
        case (op)
            OP_PPM_INTERPRET: begin
                dqaq = SEL_AQ;
                xz   = (pt == PT_ZT) ? SEL_X : SEL_Z;
                case (pt)
                    PT_ZT:        loc = SELLOC_E;
                    PT_ZB:        loc = SELLOC_EXE;
                    PT_X:         loc = SELLOC_W;
                    PT_MT, PT_MB: loc = odd ? SELLOC_WINV : SELLOC_W;
                    PT_M:         loc = (fb == FACEBD_PP) ? SELLOC_SINV : SELLOC_S;
                    default:      loc = SELLOC_ALL;
                endcase
            end
            OP_LQM_X: begin
                xz = (pt == PT_X || pt == PT_MB || pt == PT_M) ? SEL_X : SEL_Z;
                case (pt)
                    PT_ZT:       loc = SELLOC_E;
                    PT_ZB:       loc = SELLOC_NE;
                    PT_MB, PT_X: loc = SELLOC_S;
                    PT_M:        loc = SELLOC_W;
                    default:     loc = SELLOC_I;
                endcase
            end
            OP_LQM_Y: begin
                xz = (pt == PT_ZB) ? SEL_X : SEL_Z;
                case (pt)
                    PT_ZT:             loc = SELLOC_E;
                    PT_ZB:             loc = SELLOC_EXE;
                    PT_MT:             loc = SELLOC_W;
                    PT_MB, PT_M, PT_X: loc = SELLOC_WS;
                    default:           loc = SELLOC_I;
                endcase
            end
            OP_LQM_Z: begin
                case (pt)
                    PT_ZB:              loc = SELLOC_EXE;
                    PT_MT, PT_MB, PT_X: loc = SELLOC_W;
                    PT_M:               loc = SELLOC_S;
                    default:            loc = SELLOC_I;
                endcase
            end
            default: vld = 1'b0;
        endcase
        return {loc, dqaq, xz, vld};
    endfunction

    always_comb begin
        sel_meases = '0;
        sel_vld    = '0;
        any_dq     = 1'b0;
        any_pp     = 1'b0;
        for (int i = 0; i < NUM_OP; i++) begin
            if (bus.pchops[i*OPCODE_BW +: OPCODE_BW] == OP_PPM_INTERPRET) any_pp = 1'b1;
            if (bus.pchops[i*OPCODE_BW +: OPCODE_BW] inside {OP_LQM_X, OP_LQM_Y, OP_LQM_Z}) any_dq = 1'b1;
            sel_meases[i*SELMEAS_BW +: SELMEAS_BW] = bus.pchinfo_valid
                ? sel_slot(bus.pchops[i*OPCODE_BW +: OPCODE_BW], bus.pchtype, bus.facebd_n, (i % 2) == 1)
                : SEL_IDLE;
            sel_vld[i] = sel_meases[i*SELMEAS_BW];
        end
        any_dq = any_dq & bus.pchinfo_valid;
        any_pp = any_pp & bus.pchinfo_valid;
    end

    // Logical-qubit patches need no ancilla readout; merges need both.
    assign all_ready     = any_dq ? (bus.dqmeas_ready & bus.pf_ready)
                         : any_pp ? (bus.dqmeas_ready & bus.aqmeas_ready & bus.pf_ready)
                         : 1'b0;
    assign new_array_ing = (state_q == LMU_READY) & all_ready;

    always_comb begin
        state_d      = state_q;
        bpu_cnt_d    = bpu_cnt_q;
        overflow_set = 1'b0;
        case (state_q)
            LMU_READY:
                if (new_array_ing_q) state_d = LMU_PRODUCTING;
            LMU_PRODUCTING:
                if (pchinfo_rdlast_q) begin
                    state_d = LMU_INTERPRETING;
                end else if (pch_cnt_q == CNT_MAX) begin
                    state_d      = LMU_READY;
                    overflow_set = 1'b1;
                end
            LMU_INTERPRETING:
                if (bus.instinfo_rdlast) state_d = LMU_BPUPDATING;
            LMU_BPUPDATING:
                if (bpu_cnt_q == BPU_LAST) begin
                    state_d   = LMU_READY;
                    bpu_cnt_d = '0;
                end else begin
                    bpu_cnt_d = bpu_cnt_q + 1'b1;
                end
            default: state_d = LMU_READY;
        endcase

        pch_cnt_d = pch_cnt_q;
        if (state_q != LMU_READY && state_d == LMU_READY) begin
            pch_cnt_d = '0;
        end else if (bus.pchinfo_pop && state_q != LMU_READY && pch_cnt_q < CNT_MAX) begin
            pch_cnt_d = pch_cnt_q + 1'b1;
        end

        overflow_err_d = overflow_err_q;
        if (overflow_set)     overflow_err_d = 1'b1;
        else if (bus.err_clr) overflow_err_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= LMU_READY;
            bpu_cnt_q        <= '0;
            pch_cnt_q        <= '0;
            overflow_err_q   <= 1'b0;
            new_array_ing_q  <= 1'b0;
            pchinfo_rdlast_q <= 1'b0;
            sel_vld_q        <= '0;
        end else begin
            state_q          <= state_d;
            bpu_cnt_q        <= bpu_cnt_d;
            pch_cnt_q        <= pch_cnt_d;
            overflow_err_q   <= overflow_err_d;
            new_array_ing_q  <= new_array_ing;
            pchinfo_rdlast_q <= bus.pchinfo_rdlast;
            sel_vld_q        <= sel_vld;
        end
    end

    assign d_v        = bus.abcd_reg[6];
    assign c_v        = bus.abcd_reg[4];
    assign b_v        = bus.abcd_reg[2];
    assign a_v        = bus.abcd_reg[0];
    assign abcd_valid = bus.abcd_reg[7] & bus.abcd_reg[5] & bus.abcd_reg[3] & bus.abcd_reg[1];

    assign bus.state            = state_q;
    assign bus.sel_meases       = sel_meases;
    assign bus.initmeas_wrens   = (state_q == LMU_PRODUCTING) ? sel_vld_q : '0;
    assign bus.initmeas_rst     = (state_q == LMU_INTERPRETING) & (state_d != LMU_INTERPRETING);
    assign bus.pchinfo_pop      = new_array_ing_q |
                                  ((state_q == LMU_PRODUCTING) & ~pchinfo_rdlast_q & (pch_cnt_q < CNT_MAX));
    assign bus.flip_initmeas_wr = (state_q == LMU_PRODUCTING) & (state_d != LMU_PRODUCTING);
    assign bus.finmeas_wren     = (state_q == LMU_INTERPRETING);
    assign bus.byproduct_wren   = (state_q == LMU_BPUPDATING) & abcd_valid &
                                  ((~a_v & (c_v ^ d_v)) | (a_v & (b_v ^ c_v ^ d_v)));
    assign bus.abcd_rst         = abcd_valid;
    assign bus.lqsign_temp_wren = (state_q == LMU_PRODUCTING);
    assign bus.lqsign_temp_rst  = (state_q == LMU_BPUPDATING) & (bpu_cnt_q == BPU_LAST);
    assign bus.lqsign_acc_wren  = (state_q == LMU_BPUPDATING) & (bpu_cnt_q == BPU_LAST);
    assign bus.pch_cnt          = pch_cnt_q;
    assign bus.overflow_err     = overflow_err_q;
endmodule

// File: tb/tb_lmu_ctrl_param.sv
// Directed bench for lmu_ctrl_param (NUM_OP=2, BPU_CYCLES=3, MAX_PCH=4) with hand-computed expectations.
module tb_lmu_ctrl_param;
    localparam logic [2:0] OP_NOP = 3'd0, OP_PPM = 3'd1, OP_LQX = 3'd2, OP_LQY = 3'd3, OP_LQZ = 3'd4;
    localparam logic [2:0] PT_ZT = 3'd0, PT_ZB = 3'd1, PT_MT = 3'd2, PT_M = 3'd4;
    localparam logic [1:0] FB_PP = 2'd2;
    localparam int L_ALL = 0, L_E = 2, L_W = 3, L_S = 4, L_EXE = 6, L_WINV = 7, L_SINV = 8;
    localparam int ST_READY = 0, ST_PROD = 1, ST_INTERP = 2, ST_BPU = 3;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0, n_err = 0, flip_cnt = 0, prod_pops = 0;

    always #5 clk = ~clk;

    lmu_ctrl_param_if #(.NUM_OP(2), .CNT_BW(4)) bus ();

    lmu_ctrl_param #(.NUM_OP(2), .BPU_CYCLES(3), .MAX_PCH(4), .CNT_BW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One slot select: {sel_loc, sel_dqaq, sel_xz, sel_valid}
    function automatic int sm(input int loc, input int aq, input int x, input int v);
        return (loc << 3) | (aq << 2) | (x << 1) | v;
    endfunction

    function automatic int sel2(input int s1, input int s0);
        return (s1 << 7) | s0;
    endfunction

    function automatic logic [10:0] strobes();
        return {bus.initmeas_wrens, bus.initmeas_rst, bus.pchinfo_pop, bus.flip_initmeas_wr,
                bus.finmeas_wren, bus.byproduct_wren, bus.abcd_rst, bus.lqsign_temp_wren,
                bus.lqsign_temp_rst, bus.lqsign_acc_wren};
    endfunction

    // Sample flip/pop late in the current cycle, then advance to 1ns past the next edge.
    task automatic step();
        #2;
        if (bus.flip_initmeas_wr) flip_cnt++;
        if (bus.pchinfo_pop && bus.state == 2'(ST_PROD)) prod_pops++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst                 = 1'b1;
        bus.pchinfo_valid   = 1'b0;
        bus.pchtype         = '0;
        bus.facebd_n        = '0;
        bus.pchops          = '0;
        bus.dqmeas_ready    = 1'b0;
        bus.aqmeas_ready    = 1'b0;
        bus.pf_ready        = 1'b0;
        bus.pchinfo_rdlast  = 1'b0;
        bus.instinfo_rdlast = 1'b0;
        bus.abcd_reg        = '0;
        bus.err_clr         = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_state",   32'(bus.state), ST_READY);
        chk("rst_strobes", 32'(strobes()), 0);
        chk("rst_sel",     32'(bus.sel_meases), 0);
        chk("rst_ovf",     32'(bus.overflow_err), 0);
        chk("rst_cnt",     32'(bus.pch_cnt), 0);

        // Full flow: merge patch, pchtype MT
        flip_cnt = 0; prod_pops = 0;
        bus.pchops = {OP_PPM, OP_PPM}; bus.pchtype = PT_MT; bus.pchinfo_valid = 1'b1;
        bus.dqmeas_ready = 1'b1; bus.aqmeas_ready = 1'b1; bus.pf_ready = 1'b1;
        #1;
        chk("ff_sel",    32'(bus.sel_meases), sel2(sm(L_WINV, 1, 0, 1), sm(L_W, 1, 0, 1)));
        chk("ff_c0_pop", 32'(bus.pchinfo_pop), 0);
        step();
        chk("ff_c1_state", 32'(bus.state), ST_READY);
        chk("ff_c1_pop",   32'(bus.pchinfo_pop), 1);
        step();
        chk("ff_c2_state", 32'(bus.state), ST_PROD);
        chk("ff_c2_wrens", 32'(bus.initmeas_wrens), 3);
        chk("ff_c2_tmpwr", 32'(bus.lqsign_temp_wren), 1);
        bus.pchinfo_valid = 1'b0;
        step();
        chk("ff_c3_cnt", 32'(bus.pch_cnt), 1);
        step();
        bus.pchinfo_rdlast = 1'b1;
        step();
        bus.pchinfo_rdlast = 1'b0;
        chk("ff_c5_cnt",  32'(bus.pch_cnt), 3);
        chk("ff_c5_pop",  32'(bus.pchinfo_pop), 0);
        chk("ff_c5_flip", 32'(bus.flip_initmeas_wr), 1);
        step();
        chk("ff_c6_state",  32'(bus.state), ST_INTERP);
        chk("ff_c6_finwr",  32'(bus.finmeas_wren), 1);
        chk("ff_c6_imrst0", 32'(bus.initmeas_rst), 0);
        bus.instinfo_rdlast = 1'b1; bus.abcd_reg = 8'hAF;
        #1;
        chk("ff_c6_imrst1", 32'(bus.initmeas_rst), 1);
        chk("ff_c6_abcdrst", 32'(bus.abcd_rst), 1);
        chk("ff_c6_bp_off", 32'(bus.byproduct_wren), 0);
        step();
        bus.instinfo_rdlast = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("bpu_state", 32'(bus.state), ST_BPU);
            chk("bpu_bp",    32'(bus.byproduct_wren), 1);
            chk("bpu_acc",   32'(bus.lqsign_acc_wren), (k == 2) ? 1 : 0);
            chk("bpu_trst",  32'(bus.lqsign_temp_rst), (k == 2) ? 1 : 0);
            step();
        end
        chk("ff_end_state", 32'(bus.state), ST_READY);
        chk("ff_end_cnt",   32'(bus.pch_cnt), 0);
        chk("ff_flips",     32'(flip_cnt), 1);
        chk("ff_pops",      32'(prod_pops), 3);
        bus.abcd_reg = '0;

        // LQM_Y on ZB held off by pf_ready, plus other select patterns
        bus.pchops = {OP_LQY, OP_LQY}; bus.pchtype = PT_ZB; bus.pchinfo_valid = 1'b1; bus.pf_ready = 1'b0;
        #1;
        chk("lqy_sel", 32'(bus.sel_meases), sel2(sm(L_EXE, 0, 1, 1), sm(L_EXE, 0, 1, 1)));
        step();
        step();
        chk("lqy_hold_state", 32'(bus.state), ST_READY);
        chk("lqy_hold_pop",   32'(bus.pchinfo_pop), 0);
        bus.pchops = {OP_LQX, OP_LQZ}; bus.pchtype = PT_M;
        #1;
        chk("mix_sel", 32'(bus.sel_meases), sel2(sm(L_W, 0, 1, 1), sm(L_S, 0, 0, 1)));
        bus.pchops = {OP_NOP, OP_PPM}; bus.facebd_n = FB_PP;
        #1;
        chk("ppm_m_pp", 32'(bus.sel_meases), sel2(sm(L_ALL, 0, 0, 0), sm(L_SINV, 1, 0, 1)));
        bus.pchops = {OP_LQX, OP_PPM}; bus.pchtype = PT_ZT; bus.facebd_n = '0;
        #1;
        chk("ppm_zt", 32'(bus.sel_meases), sel2(sm(L_E, 0, 0, 1), sm(L_E, 1, 1, 1)));
        step();
        chk("pf_hold_state", 32'(bus.state), ST_READY);

        // Raise pf_ready, run into BPUPDATING, reset with bpu_cnt=1
        bus.pchops = {OP_LQY, OP_LQY}; bus.pchtype = PT_ZB; bus.pf_ready = 1'b1;
        step();
        chk("lqy_start_pop", 32'(bus.pchinfo_pop), 1);
        bus.pchinfo_valid = 1'b0;
        step();
        chk("lqy_prod", 32'(bus.state), ST_PROD);
        bus.pchinfo_rdlast = 1'b1;
        step();
        bus.pchinfo_rdlast = 1'b0;
        step();
        chk("lqy_interp", 32'(bus.state), ST_INTERP);
        bus.instinfo_rdlast = 1'b1;
        step();
        bus.instinfo_rdlast = 1'b0; bus.abcd_reg = 8'hBA;
        #1;
        chk("bp_a0_cxd", 32'(bus.byproduct_wren), 1);
        step();
        chk("bpu_cnt1", 32'(dut.bpu_cnt_q), 1);
        bus.abcd_reg = 8'hFA;
        #1;
        chk("bp_a0_cd_eq", 32'(bus.byproduct_wren), 0);
        bus.abcd_reg = 8'h2F;
        #1;
        chk("bp_partial", 32'(bus.byproduct_wren), 0);
        chk("abcdrst_partial", 32'(bus.abcd_rst), 0);
        rst = 1'b1;
        step();
        chk("rstbpu_state", 32'(bus.state), ST_READY);
        chk("rstbpu_cnt",   32'(dut.bpu_cnt_q), 0);
        chk("rstbpu_acc",   32'(bus.lqsign_acc_wren), 0);
        chk("rstbpu_trst",  32'(bus.lqsign_temp_rst), 0);
        chk("rstbpu_twr",   32'(bus.lqsign_temp_wren), 0);
        rst = 1'b0; bus.abcd_reg = '0;

        // Overflow: rdlast never arrives
        flip_cnt = 0; prod_pops = 0;
        bus.pchops = {OP_PPM, OP_PPM}; bus.pchtype = PT_MT; bus.pchinfo_valid = 1'b1;
        step();
        bus.pchinfo_valid = 1'b0;
        step();
        repeat (4) step();
        chk("ovf_state", 32'(bus.state), ST_PROD);
        chk("ovf_cnt",   32'(bus.pch_cnt), 4);
        chk("ovf_pop",   32'(bus.pchinfo_pop), 0);
        chk("ovf_flip",  32'(bus.flip_initmeas_wr), 1);
        chk("ovf_err0",  32'(bus.overflow_err), 0);
        step();
        chk("ovf_ready", 32'(bus.state), ST_READY);
        chk("ovf_err1",  32'(bus.overflow_err), 1);
        chk("ovf_cnt0",  32'(bus.pch_cnt), 0);
        chk("ovf_pops",  32'(prod_pops), 4);
        chk("ovf_flips", 32'(flip_cnt), 1);
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        chk("ovf_clr", 32'(bus.overflow_err), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
